// File: rtl/lsu_dmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dmem_ctrl_pkg
// Description : Shared access-size codes, FSM state encoding and the
//               alignment helper for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_dmem_ctrl_pkg;

   // Access size codes carried on mem_size
   localparam logic [1:0] LSU_SIZE_B = 2'd0;
   localparam logic [1:0] LSU_SIZE_H = 2'd1;
   localparam logic [1:0] LSU_SIZE_W = 2'd2;

   localparam int LSU_STATE_WIDTH = 2;

   typedef enum logic [LSU_STATE_WIDTH-1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_t;

   // Halfwords must sit on even bytes, words on multiples of four
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      if (size == LSU_SIZE_H) mis = off[0];
      else if (size == LSU_SIZE_W) mis = (off != 2'b00);
      return mis;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_dmem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dmem_ctrl_if
// Description : Data-memory request/response channel between the LSU
//               (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_dmem_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                req_valid;
   logic                req_ready;
   logic [ADDR_W-1:0]   addr;
   logic                wen;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wmask;
   logic                rsp_valid;
   logic [DATA_W-1:0]   rdata;

   modport master (
      output req_valid, addr, wen, wdata, wmask,
      input  req_ready, rsp_valid, rdata
   );

   modport slave (
      input  req_valid, addr, wen, wdata, wmask,
      output req_ready, rsp_valid, rdata
   );
endinterface
`default_nettype wire

// File: rtl/lsu_dmem_ctrl_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dmem_ctrl_lane_align
// Description : Combinational byte-lane steering: store mask and replicated
//               store data, plus load byte/half extraction and extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_dmem_ctrl_lane_align
   import lsu_dmem_ctrl_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   input  logic        is_unsigned,
   output logic [3:0]  wmask,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext
);

   logic [31:0] rdata_sh;

   // Lane mask/data generation and load extraction; lanes beyond 3 fall off
   always_comb begin
      rdata_sh  = rdata >> {off, 3'b000};
      wmask     = 4'b1111;
      wdata_sh  = wdata;
      rdata_ext = rdata;
      case (size)
         LSU_SIZE_B: begin
            wmask     = 4'b0001 << off;
            wdata_sh  = {4{wdata[7:0]}};
            rdata_ext = is_unsigned ? {24'h0, rdata_sh[7:0]}
                                    : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
         end
         LSU_SIZE_H: begin
            wmask     = 4'b0011 << off;
            wdata_sh  = {2{wdata[15:0]}};
            rdata_ext = is_unsigned ? {16'h0, rdata_sh[15:0]}
                                    : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
         end
         default: begin
            wmask     = 4'b1111;
            wdata_sh  = wdata;
            rdata_ext = rdata;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dmem_ctrl
// Description : Load/store unit running one data-memory transaction per op
//               over a valid/ready request and response channel.
//               Optional macro LSU_MISALIGN_CHECK_EN: misaligned H/W accesses
//               complete immediately with rsp_err and no memory request.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_dmem_ctrl
   import lsu_dmem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               mem_r_en,
   input  logic               mem_w_en,
   input  logic [ADDR_W-1:0]  mem_addr,
   input  logic [DATA_W-1:0]  mem_w,
   input  logic [1:0]         mem_size,
   input  logic               mem_unsigned,
   output logic               busy,
   output logic               rsp_valid,
   output logic [DATA_W-1:0]  rsp_rdata,
   output logic               rsp_err,
   lsu_dmem_ctrl_if.master    dmem
);

   lsu_state_t          state;
   lsu_state_t          state_nxt;
   logic                busy_nxt;
   logic                rsp_valid_nxt;
   logic                req_valid_nxt;

   logic [1:0]          size_q;
   logic [1:0]          off_q;
   logic                unsigned_q;

   logic                busy_q;
   logic                rsp_valid_q;
   logic                rsp_err_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic                req_valid_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                wen_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [3:0]          wmask_q;

   logic                accept;
   logic                misaligned;
   logic [1:0]          al_size;
   logic [1:0]          al_off;
   logic [3:0]          al_wmask;
   logic [31:0]         al_wdata;
   logic [31:0]         al_rdata;

   assign accept = in_valid & (mem_r_en | mem_w_en);

`ifdef LSU_MISALIGN_CHECK_EN
   assign misaligned = is_misaligned(mem_size, mem_addr[1:0]);
`else
   assign misaligned = 1'b0;
`endif

   // The aligner serves the incoming op while idle and the latched op afterwards
   assign al_size = (state == ST_IDLE) ? mem_size      : size_q;
   assign al_off  = (state == ST_IDLE) ? mem_addr[1:0] : off_q;

   lsu_dmem_ctrl_lane_align u_align (
      .size        (al_size),
      .off         (al_off),
      .wdata       (mem_w),
      .rdata       (dmem.rdata),
      .is_unsigned (unsigned_q),
      .wmask       (al_wmask),
      .wdata_sh    (al_wdata),
      .rdata_ext   (al_rdata)
   );

   // Next-state and next-output decode for the transaction sequencer
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = misaligned ? ST_RESP : ST_REQ;
         ST_REQ:  if (dmem.req_ready) state_nxt = ST_WAIT;
         ST_WAIT: if (dmem.rsp_valid) state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      busy_nxt      = (state_nxt == ST_REQ) || (state_nxt == ST_WAIT);
      rsp_valid_nxt = (state_nxt == ST_RESP);
      req_valid_nxt = (state_nxt == ST_REQ);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Registered outputs, op capture at accept and load data capture
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         req_valid_q <= 1'b0;
         addr_q      <= '0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         wmask_q     <= 4'b0000;
         size_q      <= LSU_SIZE_B;
         off_q       <= 2'b00;
         unsigned_q  <= 1'b0;
      end else begin
         busy_q      <= busy_nxt;
         rsp_valid_q <= rsp_valid_nxt;
         req_valid_q <= req_valid_nxt;
         rsp_err_q   <= (state == ST_IDLE) && accept && misaligned;
         if ((state == ST_IDLE) && accept) begin
            size_q      <= mem_size;
            off_q       <= mem_addr[1:0];
            unsigned_q  <= mem_unsigned;
            addr_q      <= {mem_addr[ADDR_W-1:2], 2'b00};
            wen_q       <= mem_w_en;
            wdata_q     <= al_wdata;
            wmask_q     <= mem_w_en ? al_wmask : 4'b0000;
            rsp_rdata_q <= '0;
         end
         if ((state == ST_WAIT) && dmem.rsp_valid)
            rsp_rdata_q <= wen_q ? '0 : al_rdata;
      end
   end

   assign busy           = busy_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_err        = rsp_err_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign dmem.req_valid = req_valid_q;
   assign dmem.addr      = addr_q;
   assign dmem.wen       = wen_q;
   assign dmem.wdata     = wdata_q;
   assign dmem.wmask     = wmask_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_dmem_ctrl
// Description : Directed bench for lsu_dmem_ctrl with an inline memory
//               responder and a response scoreboard queue. Expectations
//               follow LSU_MISALIGN_CHECK_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_dmem_ctrl;
   import lsu_dmem_ctrl_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_w;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic        busy;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int   n_tests;
   int   n_fail;
   exp_t sb[$];

   lsu_dmem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) dmem_bus ();

   lsu_dmem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .mem_r_en     (mem_r_en),
      .mem_w_en     (mem_w_en),
      .mem_addr     (mem_addr),
      .mem_w        (mem_w),
      .mem_size     (mem_size),
      .mem_unsigned (mem_unsigned),
      .busy         (busy),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .dmem         (dmem_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},      {31'h0, busy},               32'h0);
      check({tag, "_rsp_valid"}, {31'h0, rsp_valid},          32'h0);
      check({tag, "_rsp_err"},   {31'h0, rsp_err},            32'h0);
      check({tag, "_rsp_rdata"}, rsp_rdata,                   32'h0);
      check({tag, "_req_valid"}, {31'h0, dmem_bus.req_valid}, 32'h0);
      check({tag, "_addr"},      dmem_bus.addr,               32'h0);
      check({tag, "_wen"},       {31'h0, dmem_bus.wen},       32'h0);
      check({tag, "_wdata"},     dmem_bus.wdata,              32'h0);
      check({tag, "_wmask"},     {28'h0, dmem_bus.wmask},     32'h0);
   endtask

   // One op: present it, play memory with the given delays, score the response
   task automatic run_op(input string tag, input logic r, input logic w,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns,
                         input int rdy_dly, input int rsp_dly, input logic [31:0] mem_rd,
                         input logic exp_req, input logic [3:0] exp_mask,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                         input logic exp_err);
      exp_t        e;
      exp_t        got;
      int          cyc;
      int          req_cnt;
      int          wait_cnt;
      bit          hs;
      bit          rsp_sent;
      bit          done;
      logic [31:0] exp_addr;
      exp_addr = {addr[31:2], 2'b00};
      @(negedge clk);
      in_valid = 1'b1; mem_r_en = r; mem_w_en = w; mem_addr = addr;
      mem_w = wd; mem_size = sz; mem_unsigned = uns;
      e.rdata = exp_rdata; e.err = exp_err;
      e.lat   = exp_req ? (rdy_dly + rsp_dly + 3) : 1;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
      cyc = 1; req_cnt = 0; wait_cnt = 0; hs = 0; rsp_sent = 0; done = 0;
      while (!done && cyc < 60) begin
         if (dmem_bus.rsp_valid) dmem_bus.rsp_valid = 1'b0;
         if (dmem_bus.req_valid) begin
            if (req_cnt == 0) check({tag, "_req_issued"}, 32'h1, {31'h0, exp_req});
            if (req_cnt == 0 || req_cnt == rdy_dly) begin
               check({tag, "_addr"},  dmem_bus.addr,           exp_addr);
               check({tag, "_wen"},   {31'h0, dmem_bus.wen},   {31'h0, w});
               check({tag, "_wmask"}, {28'h0, dmem_bus.wmask}, {28'h0, exp_mask});
               check({tag, "_busy_req"}, {31'h0, busy}, 32'h1);
               if (w) check({tag, "_wdata"}, dmem_bus.wdata, exp_wdata);
            end
            if (req_cnt == rdy_dly) dmem_bus.req_ready = 1'b1;
            req_cnt++;
         end else if (dmem_bus.req_ready) begin
            dmem_bus.req_ready = 1'b0;
            hs = 1;
            check({tag, "_busy_wait"}, {31'h0, busy}, 32'h1);
         end
         if (hs && !rsp_sent) begin
            if (wait_cnt == rsp_dly) begin
               dmem_bus.rsp_valid = 1'b1;
               dmem_bus.rdata     = mem_rd;
               rsp_sent = 1;
            end
            wait_cnt++;
         end
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               check({tag, "_sb_nonempty"}, 32'h0, 32'h1);
            end else begin
               got = sb.pop_front();
               check({tag, "_rdata"}, rsp_rdata, got.rdata);
               check({tag, "_err"},   {31'h0, rsp_err}, {31'h0, got.err});
               check({tag, "_lat"},   cyc, got.lat);
            end
            check({tag, "_busy_resp"}, {31'h0, busy}, 32'h0);
            done = 1;
         end
         if (!done) begin
            @(negedge clk);
            cyc++;
         end
      end
      check({tag, "_rsp_seen"}, {31'h0, done}, 32'h1);
      dmem_bus.req_ready = 1'b0;
      dmem_bus.rsp_valid = 1'b0;
      @(negedge clk);
      check({tag, "_single_pulse"}, {31'h0, rsp_valid}, 32'h0);
      check({tag, "_idle_busy"},    {31'h0, busy},      32'h0);
   endtask

   // Directed sequence
   initial begin
      n_tests = 0; n_fail = 0;
      rst = 1'b0; in_valid = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
      mem_addr = 32'h0; mem_w = 32'h0; mem_size = LSU_SIZE_W; mem_unsigned = 1'b0;
      dmem_bus.req_ready = 1'b0; dmem_bus.rsp_valid = 1'b0; dmem_bus.rdata = 32'h0;

      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b1;

      // Stores
      run_op("sw",   1'b0, 1'b1, 32'h8000_0104, 32'hDEAD_BEEF, LSU_SIZE_W, 1'b0,
             0, 0, 32'h5555_5555, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
      run_op("sh",   1'b0, 1'b1, 32'h8000_0006, 32'h1234_ABCD, LSU_SIZE_H, 1'b0,
             0, 0, 32'h5555_5555, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0);
      run_op("sb",   1'b0, 1'b1, 32'h8000_000A, 32'h0000_00A5, LSU_SIZE_B, 1'b0,
             1, 1, 32'h5555_5555, 1'b1, 4'b0100, 32'hA5A5_A5A5, 32'h0, 1'b0);
      // Both enables: the store wins
      run_op("rw",   1'b1, 1'b1, 32'h8000_0020, 32'h0102_0304, LSU_SIZE_W, 1'b0,
             0, 0, 32'h7777_7777, 1'b1, 4'b1111, 32'h0102_0304, 32'h0, 1'b0);

      // Loads
      run_op("lbu",  1'b1, 1'b0, 32'h8000_0003, 32'h0, LSU_SIZE_B, 1'b1,
             0, 0, 32'h80FF_7F01, 1'b1, 4'b0000, 32'h0, 32'h0000_0080, 1'b0);
      run_op("lb",   1'b1, 1'b0, 32'h8000_0003, 32'h0, LSU_SIZE_B, 1'b0,
             0, 0, 32'h80FF_7F01, 1'b1, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0);
      run_op("lh",   1'b1, 1'b0, 32'h8000_0002, 32'h0, LSU_SIZE_H, 1'b0,
             0, 1, 32'h80FF_7F01, 1'b1, 4'b0000, 32'h0, 32'hFFFF_80FF, 1'b0);
      run_op("lhu",  1'b1, 1'b0, 32'h8000_0000, 32'h0, LSU_SIZE_H, 1'b1,
             0, 0, 32'h80FF_7F01, 1'b1, 4'b0000, 32'h0, 32'h0000_7F01, 1'b0);
      run_op("lw_slow", 1'b1, 1'b0, 32'h8000_0010, 32'h0, LSU_SIZE_W, 1'b0,
             5, 2, 32'hCAFE_F00D, 1'b1, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0);

      // Misaligned accesses
`ifdef LSU_MISALIGN_CHECK_EN
      run_op("lw_mis", 1'b1, 1'b0, 32'h8000_0002, 32'h0, LSU_SIZE_W, 1'b0,
             0, 0, 32'h1122_3344, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
      run_op("lh_mis", 1'b1, 1'b0, 32'h8000_0003, 32'h0, LSU_SIZE_H, 1'b0,
             0, 0, 32'h80FF_7F01, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
      run_op("sh_mis", 1'b0, 1'b1, 32'h8000_0003, 32'h0000_BEEF, LSU_SIZE_H, 1'b0,
             0, 0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
`else
      run_op("lw_mis", 1'b1, 1'b0, 32'h8000_0002, 32'h0, LSU_SIZE_W, 1'b0,
             0, 0, 32'h1122_3344, 1'b1, 4'b0000, 32'h0, 32'h1122_3344, 1'b0);
      run_op("lh_mis", 1'b1, 1'b0, 32'h8000_0003, 32'h0, LSU_SIZE_H, 1'b0,
             0, 0, 32'h80FF_7F01, 1'b1, 4'b0000, 32'h0, 32'h0000_0080, 1'b0);
      run_op("sh_mis", 1'b0, 1'b1, 32'h8000_0003, 32'h0000_BEEF, LSU_SIZE_H, 1'b0,
             0, 0, 32'h0, 1'b1, 4'b1000, 32'hBEEF_BEEF, 32'h0, 1'b0);
`endif

      // in_valid with no enable is ignored
      @(negedge clk);
      in_valid = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = 32'h8000_0040;
      @(negedge clk);
      in_valid = 1'b0;
      check("noop_busy",      {31'h0, busy},               32'h0);
      check("noop_req_valid", {31'h0, dmem_bus.req_valid}, 32'h0);
      @(negedge clk);
      check("noop_rsp_valid", {31'h0, rsp_valid},          32'h0);

      // Stray memory response while idle is ignored
      dmem_bus.rsp_valid = 1'b1; dmem_bus.rdata = 32'h1234_5678;
      @(negedge clk);
      dmem_bus.rsp_valid = 1'b0;
      check("stray_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      @(negedge clk);
      check("stray_rsp_valid2", {31'h0, rsp_valid}, 32'h0);

      // Reset while waiting for the memory response
      in_valid = 1'b1; mem_r_en = 1'b1; mem_w_en = 1'b0;
      mem_addr = 32'h8000_0020; mem_size = LSU_SIZE_W; mem_unsigned = 1'b0;
      @(negedge clk);
      in_valid = 1'b0; mem_r_en = 1'b0;
      check("rstmid_req_valid", {31'h0, dmem_bus.req_valid}, 32'h1);
      dmem_bus.req_ready = 1'b1;
      @(negedge clk);
      dmem_bus.req_ready = 1'b0;
      check("rstmid_busy_wait", {31'h0, busy}, 32'h1);
      rst = 1'b0;
      @(negedge clk);
      check_reset_vals("rstmid");
      rst = 1'b1;
      dmem_bus.rsp_valid = 1'b1; dmem_bus.rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      dmem_bus.rsp_valid = 1'b0;
      check("rstmid_late_rsp",  {31'h0, rsp_valid}, 32'h0);
      check("rstmid_late_busy", {31'h0, busy},      32'h0);
      @(negedge clk);
      check("rstmid_late_rsp2", {31'h0, rsp_valid}, 32'h0);

      check("sb_drained", sb.size(), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
